// File: rtl/sad_min_select_pkg.sv
// Shared types and constants for the SAD minimum selector.
// Contents:
//   - search geometry: 31x31 search image, 16x16 reference window, 16x16 offsets
//   - sad_t          : one SAD-engine result {sad, search-memory addr}
//   - sad_min_res_t  : final result {best, x, y}
//   - sad_better()   : strict ordering used by both the lane reduction and the running best
package sad_min_select_pkg;

    localparam int SImgSize = 31;
    localparam int RImgSize = 16;
    localparam int NumPos   = SImgSize - RImgSize + 1;
    localparam int NumRows  = NumPos;
    localparam int NumCand  = NumPos * NumPos;
    localparam int PosW     = $clog2(NumPos);
    localparam int SadLanes = 2;
    localparam int SadW     = 17;
    localparam int AddrW    = 10;
    localparam int CntW     = $clog2(NumCand + 1);

    typedef struct packed {
        logic [SadW-1:0]  sad;
        logic [AddrW-1:0] addr;
    } sad_t;

    typedef struct packed {
        sad_t            best;
        logic [PosW-1:0] x;
        logic [PosW-1:0] y;
    } sad_min_res_t;

    // True when a beats b: smaller sad, or equal sad at a lower address.
    function automatic logic sad_better(input sad_t a, input sad_t b);
        return (a.sad < b.sad) || ((a.sad == b.sad) && (a.addr < b.addr));
    endfunction

endpackage

// File: rtl/sad_lane_min.sv
// Combinational reduction of NumLanes SAD results to a single winner.
// Ports:
//   valid_i     in  NumLanes           lanes taking part in this cycle's reduction
//   sad_i       in  sad_t[NumLanes]    per-lane {sad, addr}
//   any_valid_o out 1                  at least one lane was valid
//   win_o       out sad_t              minimum sad, lower addr on ties ('0 when none valid)
module sad_lane_min
    import sad_min_select_pkg::*;
#(
    parameter int NumLanes = SadLanes
) (
    input  logic [NumLanes-1:0] valid_i,
    input  sad_t [NumLanes-1:0] sad_i,
    output logic                any_valid_o,
    output sad_t                win_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one
        // unassigned and no latch is inferred.
        any_valid_o = 1'b0;
        win_o       = '0;
        for (int i = 0; i < NumLanes; i++) begin
            // Strict comparison: an identical entry on a later lane keeps the earlier one.
            if (valid_i[i] && (!any_valid_o || sad_better(sad_i[i], win_o))) begin
                win_o       = sad_i[i];
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sad_min_select.sv
// Tracks the minimum SAD over one full search and converts its address to (x,y).
// Ports:
//   clk_i       in  1                clock
//   rst_i       in  1                synchronous active-high reset
//   start_i     in  1                begin a new search (aborts any search in progress)
//   sad_valid_i in  NumLanes         per-lane valid
//   sad_i       in  sad_t[NumLanes]  per-lane {sad, addr}
//   busy_o      out 1                searching or converting
//   done_o      out 1                one-cycle pulse, result valid
//   best_o      out sad_t            minimum sad and its address
//   best_x_o    out PosW             addr % SImgSize
//   best_y_o    out PosW             addr / SImgSize
//   err_o       out 1                sticky protocol error, cleared by start_i
module sad_min_select
    import sad_min_select_pkg::*;
#(
    parameter int NumLanes = SadLanes
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [NumLanes-1:0] sad_valid_i,
    input  sad_t [NumLanes-1:0] sad_i,
    output logic                busy_o,
    output logic                done_o,
    output sad_t                best_o,
    output logic [PosW-1:0]     best_x_o,
    output logic [PosW-1:0]     best_y_o,
    output logic                err_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StConv = 2'd2;

    localparam logic [CntW-1:0]  CandMax   = CntW'(NumCand);
    localparam logic [AddrW-1:0] RowStride = AddrW'(SImgSize);
    localparam logic [PosW-1:0]  LastRow   = PosW'(NumRows - 1);

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             first_q, first_d;
    sad_min_res_t     res_q, res_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [AddrW-1:0] rem_q, rem_d;
    logic [PosW-1:0]  row_q, row_d;

    logic [NumLanes-1:0] accept;
    logic                drop;
    logic [CntW-1:0]     taken;
    logic                win_valid;
    sad_t                win;

    // Lanes are admitted in index order until the search holds NumCand candidates;
    // anything beyond that in the final cycle is dropped and flagged.
    always_comb begin
        accept = '0;
        drop   = 1'b0;
        taken  = '0;
        for (int i = 0; i < NumLanes; i++) begin
            if (sad_valid_i[i]) begin
                if ((count_q + taken) < CandMax) begin
                    accept[i] = 1'b1;
                    taken     = taken + CntW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    sad_lane_min #(
        .NumLanes (NumLanes)
    ) u_lane_min (
        .valid_i     (accept),
        .sad_i       (sad_i),
        .any_valid_o (win_valid),
        .win_o       (win)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        first_d = first_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        row_d   = row_q;

        if (start_i) begin
            // Lanes presented alongside start belong to no search and are ignored.
            state_d = StRun;
            count_d = '0;
            first_d = 1'b1;
            res_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (drop) begin
                        err_d = 1'b1;
                    end
                    count_d = count_q + taken;
                    if (win_valid && (first_q || sad_better(win, res_q.best))) begin
                        res_d.best = win;
                        first_d    = 1'b0;
                    end
                    if (count_d == CandMax) begin
                        state_d = StConv;
                        rem_d   = res_d.best.addr;
                        row_d   = '0;
                    end
                end
                StConv: begin
                    if (|sad_valid_i) begin
                        err_d = 1'b1;
                    end
                    // Repeated subtraction divider, one row per cycle, capped at the last row.
                    if ((rem_q >= RowStride) && (row_q != LastRow)) begin
                        rem_d = rem_q - RowStride;
                        row_d = row_q + PosW'(1);
                    end else begin
                        // Still >= one row at the cap means the address lies outside the grid.
                        if (rem_q >= RowStride) begin
                            err_d = 1'b1;
                        end
                        res_d.x = rem_q[PosW-1:0];
                        res_d.y = row_q;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    if (|sad_valid_i) begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            first_q <= 1'b1;
            res_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            first_q <= first_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            row_q   <= row_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = done_q;
    assign best_o   = res_q.best;
    assign best_x_o = res_q.x;
    assign best_y_o = res_q.y;
    assign err_o    = err_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Self-checking bench for sad_min_select: directed searches plus randomized ones,
// all compared against a list-based reference model of one search.
module tb_sad_min_select;
    import sad_min_select_pkg::*;

    typedef struct packed {
        logic [1:0] v;
        sad_t       s1;
        sad_t       s0;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      valid;
    sad_t [1:0]      sad;
    logic            busy;
    logic            done;
    sad_t            best;
    logic [PosW-1:0] bx;
    logic [PosW-1:0] by;
    logic            err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    beat_t beats[$];

    always #5 clk = ~clk;

    sad_min_select #(
        .NumLanes (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .sad_valid_i (valid),
        .sad_i       (sad),
        .busy_o      (busy),
        .done_o      (done),
        .best_o      (best),
        .best_x_o    (bx),
        .best_y_o    (by),
        .err_o       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // 256 candidates on the offset grid, two per beat, addr = row*31 + col.
    task automatic build_grid(input logic [16:0] s);
        beats.delete();
        for (int k = 0; k < NumCand / 2; k++) begin
            beat_t b;
            b.v       = 2'b11;
            b.s0.sad  = s;
            b.s0.addr = 10'(((2 * k) / 16) * SImgSize + (2 * k) % 16);
            b.s1.sad  = s;
            b.s1.addr = 10'(((2 * k + 1) / 16) * SImgSize + (2 * k + 1) % 16);
            beats.push_back(b);
        end
    endtask

    task automatic set_sad_at(input int addr, input logic [16:0] s);
        for (int k = 0; k < beats.size(); k++) begin
            beat_t b;
            b = beats[k];
            if (int'(b.s0.addr) == addr) b.s0.sad = s;
            if (int'(b.s1.addr) == addr) b.s1.sad = s;
            beats[k] = b;
        end
    endtask

    task automatic set_lane(input int k, input int lane, input logic [16:0] s, input int addr);
        beat_t b;
        b = beats[k];
        if (lane == 0) b.s0 = {s, 10'(addr)};
        else           b.s1 = {s, 10'(addr)};
        beats[k] = b;
    endtask

    task automatic gen_random(input int sad_max, input int addr_max);
        int n;
        beats.delete();
        n = 0;
        while (n < NumCand) begin
            beat_t b;
            b.v  = 2'($urandom_range(0, 3));
            b.s0 = {17'($urandom_range(0, sad_max)), 10'($urandom_range(0, addr_max))};
            b.s1 = {17'($urandom_range(0, sad_max)), 10'($urandom_range(0, addr_max))};
            n += int'(b.v[0]) + int'(b.v[1]);
            beats.push_back(b);
        end
        for (int e = $urandom_range(0, 2); e > 0; e--) begin
            beat_t b;
            b.v  = 2'b11;
            b.s0 = {17'($urandom_range(0, sad_max)), 10'($urandom_range(0, 1023))};
            b.s1 = {17'($urandom_range(0, sad_max)), 10'($urandom_range(0, 1023))};
            beats.push_back(b);
        end
    endtask

    // Reference: the first NumCand valid lanes (beat order, then lane order) form the
    // candidate set; anything else valid is a protocol error. The winner is the lowest
    // address among those sharing the smallest sad. Offsets come from integer division.
    task automatic model(output sad_t eb, output logic [3:0] ex, output logic [3:0] ey,
                         output logic eerr, output int fin);
        sad_t        acc[$];
        int          n;
        logic [16:0] ms;
        int          ma;
        int          yr;
        n    = 0;
        eerr = 1'b0;
        fin  = -1;
        foreach (beats[k]) begin
            for (int l = 0; l < 2; l++) begin
                if (beats[k].v[l]) begin
                    if (n < NumCand) begin
                        acc.push_back(l == 0 ? beats[k].s0 : beats[k].s1);
                        n++;
                        if (n == NumCand) fin = k;
                    end else begin
                        eerr = 1'b1;
                    end
                end
            end
        end
        ms = '1;
        foreach (acc[i]) if (acc[i].sad < ms) ms = acc[i].sad;
        ma = 1024;
        foreach (acc[i]) if (acc[i].sad == ms && int'(acc[i].addr) < ma) ma = int'(acc[i].addr);
        eb = {ms, 10'(ma)};
        yr = ma / SImgSize;
        if (yr > NumRows - 1) begin
            eerr = 1'b1;
            ey   = 4'(NumRows - 1);
            ex   = 4'((ma - (NumRows - 1) * SImgSize) % 16);
        end else begin
            ey = 4'(yr);
            ex = 4'(ma % SImgSize);
        end
    endtask

    task automatic run_search(input string tag);
        sad_t       eb;
        logic [3:0] ex;
        logic [3:0] ey;
        logic       eerr;
        int         fin;
        int         t_final;
        int         done_n;
        int         done_at;
        model(eb, ex, ey, eerr, fin);
        t_final = -100;
        done_n  = 0;
        done_at = -1;
        // Lanes valid during the start cycle carry a would-be winner; they must be ignored.
        start    = 1'b1;
        valid    = 2'b11;
        sad[0]   = {17'd0, 10'd0};
        sad[1]   = {17'd0, 10'd1};
        step();
        start = 1'b0;
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        foreach (beats[k]) begin
            valid  = beats[k].v;
            sad[0] = beats[k].s0;
            sad[1] = beats[k].s1;
            if (k == fin) t_final = cyc;
            step();
            if (done) begin
                done_n++;
                done_at = cyc;
            end
        end
        valid = 2'b00;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) begin
                done_n++;
                done_at = cyc;
            end
        end
        check({tag, "_done_count"}, 32'(done_n), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_at), 32'(t_final + int'(ey) + 2));
        check({tag, "_best"}, 32'(best), 32'(eb));
        check({tag, "_x"}, 32'(bx), 32'(ex));
        check({tag, "_y"}, 32'(by), 32'(ey));
        check({tag, "_err"}, 32'(err), 32'(eerr));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        rst    = 1'b1;
        start  = 1'b0;
        valid  = 2'b00;
        sad[0] = '0;
        sad[1] = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_best", 32'(best), 32'd0);
        check("rst_x", 32'(bx), 32'd0);
        check("rst_y", 32'(by), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Single clear minimum: {12,226} -> x=9, y=7.
        build_grid(17'd1000);
        set_sad_at(226, 17'd12);
        run_search("grid_min");

        // Abort a search in progress; its very small sad must not survive the restart.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            valid  = 2'b11;
            sad[0] = {17'd0, 10'd7};
            sad[1] = {17'd0, 10'd8};
            step();
        end
        // Ties: same-cycle tie resolved by address, then a later lower address wins.
        build_grid(17'd900);
        set_lane(0, 0, 17'd5, 35);
        set_lane(0, 1, 17'd5, 40);
        set_lane(60, 0, 17'd5, 20);
        run_search("ties");

        // All-maximum sad: first/lowest address is kept.
        build_grid(17'h1FFFF);
        run_search("all_max");

        // Last grid position: 16 conversion cycles.
        build_grid(17'd1000);
        set_sad_at(480, 17'd3);
        run_search("corner");

        // Reset part way through a search.
        build_grid(17'd700);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            valid  = beats[k].v;
            sad[0] = beats[k].s0;
            sad[1] = beats[k].s1;
            step();
        end
        rst   = 1'b1;
        valid = 2'b00;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_best", 32'(best), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        gen_random(63, 495);
        run_search("after_rst");

        // Valid lanes in IDLE set a sticky error.
        valid  = 2'b01;
        sad[0] = {17'd1, 10'd1};
        step();
        valid = 2'b00;
        check("idle_valid_err", 32'(err), 32'd1);
        step();
        check("idle_err_sticky", 32'(err), 32'd1);

        // Overflow in the final cycle plus lanes during conversion; dropped sads are 0.
        build_grid(17'd500);
        set_sad_at(100, 17'd7);
        beats[0].v = 2'b01;
        beats.push_back({2'b11, {17'd0, 10'd6}, {17'd600, 10'd5}});
        beats.push_back({2'b11, {17'd0, 10'd9}, {17'd0, 10'd8}});
        run_search("overflow");
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_clears_err", 32'(err), 32'd0);

        // Randomized searches: tie-heavy small sads, full-range sads, out-of-grid addresses.
        gen_random(15, 495);
        run_search("rand_ties");
        gen_random(131071, 495);
        run_search("rand_full");
        gen_random(31, 1023);
        run_search("rand_addr");
        gen_random(3, 1023);
        run_search("rand_mix");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
